// File: rtl/fir_pkg.sv
// Shared definitions for the folded FIR engine.
// Holds the controller state type and the width helpers used to size
// the accumulator and the sample/coefficient address buses.
package fir_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } fir_sched_state_t;

    // Accumulator width: product width plus enough guard bits for TAPS terms.
    function automatic int accubits(input int multbits, input int taps);
        return multbits + $clog2(taps);
    endfunction

    // Address width able to index TAPS entries (at least one bit).
    function automatic int addr_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/fir_sample_ram.sv
// Single-port sample history memory for the folded FIR engine.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset (read register only)
//   we    - write enable
//   addr  - shared read/write address
//   wdata - write data
//   rdata - registered read data, valid one cycle after addr
// The array itself is not reset; the controller zeroes it explicitly.
module fir_sample_ram #(
    parameter int DEPTH = 401,
    parameter int WIDTH = 16,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Folded FIR controller: one multiply-accumulate sequenced over all taps.
// Ports:
//   clk, rst_n          - clock and synchronous active-low reset
//   s_valid/s_ready     - input sample handshake, s_data signed sample
//   coef_addr/coef_data - external coefficient ROM, 1-cycle read latency
//   m_valid/m_ready     - output handshake, m_data signed filter result
module fir_mac_scheduler
    import fir_pkg::*;
#(
    parameter  int TAPS     = 401,
    parameter  int DATABITS = 16,
    parameter  int COEFBITS = 16,
    parameter  int MULTBITS = DATABITS + COEFBITS,
    localparam int ACCUBITS = accubits(MULTBITS, TAPS),
    localparam int AW       = addr_width(TAPS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [DATABITS-1:0] s_data,
    output logic        [AW-1:0]       coef_addr,
    input  logic signed [COEFBITS-1:0] coef_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [ACCUBITS-1:0] m_data
);

    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
    localparam logic [AW-1:0] ONE_A    = AW'(1);

    fir_sched_state_t            state_r, state_next_s;
    logic        [AW-1:0]        k_r, wr_ptr_r, rd_addr_s;
    logic        [AW:0]          rd_sum_s;
    logic                        accept_s;
    logic                        ram_we_s;
    logic        [AW-1:0]        ram_addr_s;
    logic        [DATABITS-1:0]  ram_wdata_s, ram_rdata_s;
    logic                        v1_r, v2_r;
    logic signed [MULTBITS-1:0]  prod_s, prod_r;
    logic signed [ACCUBITS-1:0]  acc_r, acc_next_s;
    logic                        s_ready_r, m_valid_r;
    logic signed [ACCUBITS-1:0]  m_data_r;

    assign accept_s  = (state_r == ST_IDLE) && s_valid && s_ready_r;
    assign coef_addr = (state_r == ST_ISSUE) ? k_r : '0;
    assign s_ready   = s_ready_r;
    assign m_valid   = m_valid_r;
    assign m_data    = m_data_r;

    // Newest-first read address: (wr_ptr - k) mod TAPS with one-step wrap.
    always_comb begin
        if (k_r > wr_ptr_r) begin
            rd_sum_s = {1'b0, wr_ptr_r} + (AW+1)'(TAPS) - {1'b0, k_r};
        end else begin
            rd_sum_s = {1'b0, wr_ptr_r} - {1'b0, k_r};
        end
        rd_addr_s = rd_sum_s[AW-1:0];
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: state_next_s = (k_r == LAST_TAP) ? ST_IDLE : ST_CLEAR;
            ST_IDLE:  state_next_s = accept_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_next_s = (k_r == LAST_TAP) ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_next_s = (k_r == ONE_A) ? ST_OUT : ST_DRAIN;
            ST_OUT:   state_next_s = m_ready ? ST_IDLE : ST_OUT;
            default:  state_next_s = ST_CLEAR;
        endcase
    end

    // Sample RAM port steering: zero-fill, sample write, or history read.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = '0;
        ram_wdata_s = '0;
        case (state_r)
            ST_CLEAR: begin
                ram_we_s   = 1'b1;
                ram_addr_s = k_r;
            end
            ST_IDLE: begin
                ram_we_s    = accept_s;
                ram_addr_s  = wr_ptr_r;
                ram_wdata_s = s_data;
            end
            ST_ISSUE: ram_addr_s = rd_addr_s;
            default:  ram_addr_s = '0;
        endcase
    end

    fir_sample_ram #(
        .DEPTH (TAPS),
        .WIDTH (DATABITS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Product of the registered operands and the sign-extended accumulate.
    always_comb begin
        prod_s = MULTBITS'($signed(ram_rdata_s) * coef_data);
        if (v2_r) begin
            acc_next_s = acc_r + {{(ACCUBITS-MULTBITS){prod_r[MULTBITS-1]}}, prod_r};
        end else begin
            acc_next_s = acc_r;
        end
    end

    // State register, tap/drain counter and write pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_CLEAR;
            k_r      <= '0;
            wr_ptr_r <= '0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_CLEAR: begin
                    k_r      <= (k_r == LAST_TAP) ? '0 : k_r + ONE_A;
                    wr_ptr_r <= '0;
                end
                ST_IDLE:  k_r <= '0;
                ST_ISSUE: k_r <= (k_r == LAST_TAP) ? '0 : k_r + ONE_A;
                ST_DRAIN: k_r <= (k_r == ONE_A) ? '0 : k_r + ONE_A;
                ST_OUT: begin
                    if (m_ready) begin
                        wr_ptr_r <= (wr_ptr_r == LAST_TAP) ? '0 : wr_ptr_r + ONE_A;
                    end
                end
                default: k_r <= '0;
            endcase
        end
    end

    // MAC pipeline: issue -> operands valid -> product registered -> accumulate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r   <= 1'b0;
            v2_r   <= 1'b0;
            prod_r <= '0;
            acc_r  <= '0;
        end else begin
            v1_r <= (state_r == ST_ISSUE);
            v2_r <= v1_r;
            if (v1_r) begin
                prod_r <= prod_s;
            end
            if (accept_s) begin
                acc_r <= '0;
            end else begin
                acc_r <= acc_next_s;
            end
        end
    end

    // Registered handshake flags and output hold register. The last product
    // lands on the DRAIN->OUT edge, so the result is taken from acc_next_s.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
        end else begin
            s_ready_r <= (state_next_s == ST_IDLE);
            m_valid_r <= (state_next_s == ST_OUT);
            if ((state_r == ST_DRAIN) && (state_next_s == ST_OUT)) begin
                m_data_r <= acc_next_s;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: one TAPS=4 and one TAPS=5 instance, each
// with its own registered coefficient ROM and a convolution reference model.
module tb_fir_mac_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               s_valid4, s_valid5, m_ready4, m_ready5;
    logic signed [15:0] s_data;
    logic               s_ready4, s_ready5, m_valid4, m_valid5;
    logic        [1:0]  coef_addr4;
    logic        [2:0]  coef_addr5;
    logic signed [15:0] coef_data4, coef_data5;
    logic signed [33:0] m_data4;
    logic signed [34:0] m_data5;

    logic signed [15:0] coef4 [4];
    logic signed [15:0] coef5 [8];
    longint             hist4 [4];
    longint             hist5 [5];

    int total = 0;
    int bad   = 0;

    always @(posedge clk) begin
        coef_data4 <= coef4[coef_addr4];
        coef_data5 <= coef5[coef_addr5];
    end

    fir_mac_scheduler #(.TAPS(4), .DATABITS(16), .COEFBITS(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid4), .s_ready(s_ready4),
        .s_data(s_data), .coef_addr(coef_addr4), .coef_data(coef_data4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4)
    );

    fir_mac_scheduler #(.TAPS(5), .DATABITS(16), .COEFBITS(16)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid5), .s_ready(s_ready5),
        .s_data(s_data), .coef_addr(coef_addr5), .coef_data(coef_data5),
        .m_valid(m_valid5), .m_ready(m_ready5), .m_data(m_data5)
    );

    typedef struct {
        int     mode;   // 0: coefs 1,2,3,4   1: all coefs -32768
        longint x;
        longint exp;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sr(input int d);
        return (d == 4) ? longint'(s_ready4) : longint'(s_ready5);
    endfunction

    function automatic longint mv(input int d);
        return (d == 4) ? longint'(m_valid4) : longint'(m_valid5);
    endfunction

    function automatic longint md(input int d);
        return (d == 4) ? longint'(m_data4) : longint'(m_data5);
    endfunction

    task automatic drive_sv(input int d, input logic v);
        if (d == 4) s_valid4 = v; else s_valid5 = v;
    endtask

    task automatic drive_mr(input int d, input logic v);
        if (d == 4) m_ready4 = v; else m_ready5 = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist4[i] = 0;
        for (int i = 0; i < 5; i++) hist5[i] = 0;
    endtask

    // y[n] = sum_k c[k] * x[n-k], history kept newest first.
    task automatic model_push(input int d, input longint x, output longint y);
        y = 0;
        if (d == 4) begin
            for (int i = 3; i > 0; i--) hist4[i] = hist4[i-1];
            hist4[0] = x;
            for (int i = 0; i < 4; i++) y += longint'(coef4[i]) * hist4[i];
        end else begin
            for (int i = 4; i > 0; i--) hist5[i] = hist5[i-1];
            hist5[0] = x;
            for (int i = 0; i < 5; i++) y += longint'(coef5[i]) * hist5[i];
        end
    endtask

    task automatic set_coef4(input int mode);
        for (int i = 0; i < 4; i++) coef4[i] = (mode == 0) ? 16'(i + 1) : 16'sh8000;
    endtask

    function automatic longint rnd16();
        logic signed [15:0] r;
        r = 16'($urandom);
        return longint'(r);
    endfunction

    // Pulse reset, then check the CLEAR window on both instances.
    task automatic reset_seq(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check({name, " mv4 in reset"}, mv(4), 0);
            check({name, " mv5 in reset"}, mv(5), 0);
        end
        rst_n = 1'b1;
        model_reset();
        check({name, " m_data4 reset"}, md(4), 0);
        check({name, " coef_addr4 reset"}, longint'(coef_addr4), 0);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("%s s_ready4 c%0d", name, c), sr(4), (c >= 4) ? 1 : 0);
            check($sformatf("%s s_ready5 c%0d", name, c), sr(5), (c >= 5) ? 1 : 0);
            check($sformatf("%s m_valid4 c%0d", name, c), mv(4), 0);
            @(negedge clk);
        end
    endtask

    // One full transaction; optional output stall with an offered sample.
    task automatic send(input int d, input longint x, input longint exp,
                        input string name, input int hold);
        int n;
        @(negedge clk);
        n = 0;
        while (sr(d) == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " s_ready"}, sr(d), 1);
        s_data = 16'(x);
        drive_sv(d, 1'b1);
        @(posedge clk);
        #1 drive_sv(d, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mv(d) == 0 && n < 60);
        check({name, " latency"}, n, d + 3);
        check({name, " data"}, md(d), exp);
        if (hold > 0) begin
            s_data = 16'sh3039;
            drive_sv(d, 1'b1);
            for (int c = 0; c < hold; c++) begin
                check($sformatf("%s stall mv c%0d", name, c), mv(d), 1);
                check($sformatf("%s stall data c%0d", name, c), md(d), exp);
                check($sformatf("%s stall s_ready c%0d", name, c), sr(d), 0);
                @(negedge clk);
            end
            drive_sv(d, 1'b0);
        end
        drive_mr(d, 1'b1);
        @(posedge clk);
        #1 drive_mr(d, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t   tbl [9];
        longint y;
        longint x;

        rst_n = 1'b0;
        s_valid4 = 1'b0; s_valid5 = 1'b0;
        m_ready4 = 1'b0; m_ready5 = 1'b0;
        s_data = '0;
        set_coef4(0);
        for (int i = 0; i < 8; i++) coef5[i] = 16'(i + 1);
        model_reset();

        reset_seq("rst");

        // Impulse response, then extremes with full-scale negative operands.
        tbl[0] = '{0, 1, 1};
        tbl[1] = '{0, 0, 2};
        tbl[2] = '{0, 0, 3};
        tbl[3] = '{0, 0, 4};
        tbl[4] = '{0, 0, 0};
        tbl[5] = '{1, -32768, 64'sd1073741824};
        tbl[6] = '{1, -32768, 64'sd2147483648};
        tbl[7] = '{1, -32768, 64'sd3221225472};
        tbl[8] = '{1, -32768, 64'sd4294967296};
        for (int i = 0; i < 9; i++) begin
            set_coef4(tbl[i].mode);
            model_push(4, tbl[i].x, y);
            send(4, tbl[i].x, tbl[i].exp, $sformatf("vec%0d", i), 0);
        end

        // Mixed-sign random coefficients and samples.
        for (int i = 0; i < 4; i++) coef4[i] = 16'(rnd16());
        for (int i = 0; i < 8; i++) begin
            x = rnd16();
            model_push(4, x, y);
            send(4, x, y, $sformatf("mixed%0d", i), 0);
        end

        // Output backpressure with an offered sample that must be ignored.
        x = rnd16();
        model_push(4, x, y);
        send(4, x, y, "stall", 10);

        // Pointer wrap on both depths.
        for (int i = 0; i < 5; i++) coef5[i] = 16'(rnd16());
        for (int i = 0; i < 10; i++) begin
            x = rnd16();
            model_push(4, x, y);
            send(4, x, y, $sformatf("wrap4_%0d", i), 0);
            x = rnd16();
            model_push(5, x, y);
            send(5, x, y, $sformatf("wrap5_%0d", i), 0);
        end

        // Reset while ISSUE is running: result dropped, history re-zeroed.
        @(negedge clk);
        s_data = 16'sh1234;
        s_valid4 = 1'b1;
        @(posedge clk);
        #1 s_valid4 = 1'b0;
        @(negedge clk);
        reset_seq("midrst");
        set_coef4(0);
        for (int i = 0; i < 4; i++) begin
            x = (i == 0) ? 1 : 0;
            model_push(4, x, y);
            send(4, x, longint'(i + 1), $sformatf("post_rst%0d", i), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
